// File: rtl/seg_display_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg_display_pkg
// Description : Shared types and constants for the seg_display block.
//               - state_t    : display FSM state encoding
//               - c_hex_seg  : 16-entry hex-digit to segment table (g..a)
//               - c_blank    : all-segments-off pattern
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package seg_display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHOW  = 2'd1,
    ST_BLANK = 2'd2
  } state_t;

  // Bit 6 = g ... bit 0 = a, 1 = lit. Entry 15 is listed first (MSB end).
  localparam logic [15:0][6:0] c_hex_seg = {
    7'h71,  // F
    7'h79,  // E
    7'h5E,  // d
    7'h39,  // C
    7'h7C,  // b
    7'h77,  // A
    7'h6F,  // 9
    7'h7F,  // 8
    7'h07,  // 7
    7'h7D,  // 6
    7'h6D,  // 5
    7'h66,  // 4
    7'h4F,  // 3
    7'h5B,  // 2
    7'h06,  // 1
    7'h3F   // 0
  };

  localparam logic [6:0] c_blank = 7'h00;

endpackage : seg_display_pkg
`default_nettype wire

// File: rtl/seg_display_if.sv
`default_nettype none
// ============================================================================
// Module      : seg_display_if
// Description : Bus bundle between a controller (master) and seg_display
//               (slave).
// Signals     : load     - capture request (level)
//               value    - 4-bit value to display
//               blink_en - enable blinking on 0 / 15
//               ack      - one-cycle capture confirmation
//               shown    - currently captured value
//               SEG      - {dp, g..a} segment drive, 1 = lit
// Revision    : 1.0 - initial release
// ============================================================================
interface seg_display_if;

  logic       load;
  logic [3:0] value;
  logic       blink_en;
  logic       ack;
  logic [3:0] shown;
  logic [7:0] SEG;

  modport master (
    output load, value, blink_en,
    input  ack, shown, SEG
  );

  modport slave (
    input  load, value, blink_en,
    output ack, shown, SEG
  );

endinterface : seg_display_if
`default_nettype wire

// File: rtl/seg_display_hex_to_seg.sv
`default_nettype none
// ============================================================================
// Module      : hex_to_seg
// Description : Combinational hex digit to 7-segment (g..a) lookup.
// Ports       : i_hex [3:0] - hex digit
//               o_seg [6:0] - segment pattern, bit 6 = g ... bit 0 = a
// Revision    : 1.0 - initial release
// ============================================================================
module hex_to_seg
  import seg_display_pkg::*;
(
  input  wire logic [3:0] i_hex,
  output logic      [6:0] o_seg
);

  assign o_seg = c_hex_seg[i_hex];

endmodule : hex_to_seg
`default_nettype wire

// File: rtl/seg_display.sv
`default_nettype none
// ============================================================================
// Module      : seg_display
// Description : Captures a 4-bit value on request and drives a 7-segment
//               display with it; 0 and 15 may blink. Optional heartbeat on
//               the decimal point, enabled by defining SEG_HEARTBEAT_EN.
// Parameters  : BLINK_CYCLES - cycles per blink half-period (2..255)
//               HB_CYCLES    - cycles per heartbeat half-period (2..255)
// Ports       : clk_2   - clock, all state changes on its rising edge
//               reset_n - synchronous active-low reset
//               bus     - seg_display_if slave modport
// Revision    : 1.0 - initial release
// ============================================================================
module seg_display
  import seg_display_pkg::*;
#(
  parameter int BLINK_CYCLES = 4,
  parameter int HB_CYCLES    = 8
)(
  input  wire logic       clk_2,
  input  wire logic       reset_n,
  seg_display_if.slave    bus
);

  // Out-of-range parameters would break the 8-bit counters' terminal compare.
  if (BLINK_CYCLES < 2 || BLINK_CYCLES > 255 ||
      HB_CYCLES < 2 || HB_CYCLES > 255) begin : g_param_check
    $error("seg_display: BLINK_CYCLES/HB_CYCLES must be in 2..255");
  end

  localparam logic [7:0] c_blink_last = 8'(BLINK_CYCLES - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_shown;
  logic [3:0] w_shown_nxt;
  logic [7:0] r_blink_cnt;
  logic [7:0] w_blink_nxt;
  logic       r_ack;
  logic       w_ack_nxt;
  logic [6:0] r_seg;
  logic [6:0] w_seg_nxt;
  logic [6:0] w_hex;
  logic       w_blink_cond;
  logic       w_dp;

  assign w_blink_cond = bus.blink_en && ((r_shown == 4'h0) || (r_shown == 4'hF));

  // Next-state / next-output logic. Load wins over any blink activity.
  always_comb begin
    w_state_nxt = r_state;
    w_shown_nxt = r_shown;
    w_blink_nxt = 8'd0;
    w_ack_nxt   = 1'b0;
    if (bus.load) begin
      w_state_nxt = ST_SHOW;
      w_shown_nxt = bus.value;
      w_ack_nxt   = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: w_state_nxt = ST_IDLE;
        ST_SHOW, ST_BLANK: begin
          if (w_blink_cond) begin
            if (r_blink_cnt == c_blink_last) begin
              w_state_nxt = (r_state == ST_SHOW) ? ST_BLANK : ST_SHOW;
            end else begin
              w_blink_nxt = r_blink_cnt + 8'd1;
            end
          end else begin
            // Blink condition gone: always fall back to a lit display.
            w_state_nxt = ST_SHOW;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Segment register is loaded from next-state values so the pattern is
  // visible in the same cycle as the ack for a capture.
  hex_to_seg u_hex_to_seg (
    .i_hex (w_shown_nxt),
    .o_seg (w_hex)
  );

  assign w_seg_nxt = (w_state_nxt == ST_SHOW) ? w_hex : c_blank;

  always_ff @(posedge clk_2) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_shown     <= 4'h0;
      r_blink_cnt <= 8'd0;
      r_ack       <= 1'b0;
      r_seg       <= c_blank;
    end else begin
      r_state     <= w_state_nxt;
      r_shown     <= w_shown_nxt;
      r_blink_cnt <= w_blink_nxt;
      r_ack       <= w_ack_nxt;
      r_seg       <= w_seg_nxt;
    end
  end

`ifdef SEG_HEARTBEAT_EN
  localparam logic [7:0] c_hb_last = 8'(HB_CYCLES - 1);

  logic [7:0] r_hb_cnt;
  logic       r_hb;

  always_ff @(posedge clk_2) begin
    if (!reset_n) begin
      r_hb_cnt <= 8'd0;
      r_hb     <= 1'b0;
    end else if (r_state == ST_IDLE) begin
      r_hb_cnt <= 8'd0;
      r_hb     <= 1'b0;
    end else if (r_hb_cnt == c_hb_last) begin
      r_hb_cnt <= 8'd0;
      r_hb     <= ~r_hb;
    end else begin
      r_hb_cnt <= r_hb_cnt + 8'd1;
    end
  end

  assign w_dp = r_hb;
`else
  assign w_dp = 1'b0;
`endif

  assign bus.ack   = r_ack;
  assign bus.shown = r_shown;
  assign bus.SEG   = {w_dp, r_seg};

endmodule : seg_display
`default_nettype wire

// File: tb/tb_seg_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_display
// Description : Directed self-checking bench for seg_display
//               (BLINK_CYCLES=4, HB_CYCLES=8). Heartbeat checks are built
//               when SEG_HEARTBEAT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_display;

  logic clk_2;
  logic reset_n;
  int   n_checks;
  int   n_pass;

  seg_display_if bus ();

  seg_display #(
    .BLINK_CYCLES (4),
    .HB_CYCLES    (8)
  ) u_dut (
    .clk_2   (clk_2),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk_2 = 1'b0;
  always #5 clk_2 = ~clk_2;

  // Hand-computed g..a patterns for 0..F.
  logic [6:0] exp_hex [16];
  initial begin
    exp_hex = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  end

  task automatic tick();
    @(posedge clk_2);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    bus.load     = 1'b0;
    bus.value    = 4'h0;
    bus.blink_en = 1'b0;
    reset_n      = 1'b0;

    // Reset state
    tick(); tick();
    reset_n = 1'b1;
    tick();
    check("rst_seg",   32'(bus.SEG),   32'h00);
    check("rst_shown", 32'(bus.shown), 32'h0);
    check("rst_ack",   32'(bus.ack),   32'h0);
    tick();
    check("idle_seg", 32'(bus.SEG), 32'h00);

    // Reset beats a simultaneous load
    reset_n = 1'b0; bus.load = 1'b1; bus.value = 4'h7;
    tick();
    reset_n = 1'b1; bus.load = 1'b0;
    check("rst_over_load_shown", 32'(bus.shown), 32'h0);
    check("rst_over_load_ack",   32'(bus.ack),   32'h0);
    check("rst_over_load_seg",   32'(bus.SEG[6:0]), 32'h00);

    // Single load of 3
    bus.load = 1'b1; bus.value = 4'h3;
    tick();
    bus.load = 1'b0;
    check("ld3_ack",   32'(bus.ack),      32'h1);
    check("ld3_shown", 32'(bus.shown),    32'h3);
    check("ld3_seg",   32'(bus.SEG[6:0]), 32'h4F);
    tick();
    check("ld3_ack_drop", 32'(bus.ack),      32'h0);
    check("ld3_seg_hold", 32'(bus.SEG[6:0]), 32'h4F);
`ifndef SEG_HEARTBEAT_EN
    check("dp_off_show", 32'(bus.SEG[7]), 32'h0);
`endif

    // Back-to-back loads 1,2,3
    for (int i = 1; i <= 3; i++) begin
      bus.load = 1'b1; bus.value = 4'(i);
      tick();
      check("b2b_ack",   32'(bus.ack),   32'h1);
      check("b2b_shown", 32'(bus.shown), 32'(i));
    end
    bus.load = 1'b0;
    tick();
    check("b2b_ack_end",   32'(bus.ack),   32'h0);
    check("b2b_shown_end", 32'(bus.shown), 32'h3);

    // Full table sweep, blinking disabled
    for (int v = 0; v < 16; v++) begin
      bus.load = 1'b1; bus.value = 4'(v);
      tick();
      check("hex_seg", 32'(bus.SEG[6:0]), 32'(exp_hex[v]));
    end
    bus.load = 1'b0;
    tick();
    check("no_blink_F", 32'(bus.SEG[6:0]), 32'h71);

    // Blink on F: 4 cycles lit, 4 cycles blank
    bus.blink_en = 1'b1; bus.load = 1'b1; bus.value = 4'hF;
    tick();
    bus.load = 1'b0;
    check("blinkF_k0", 32'(bus.SEG[6:0]), 32'h71);
    for (int k = 1; k <= 6; k++) begin
      tick();
      check("blinkF", 32'(bus.SEG[6:0]), ((k / 4) % 2 == 1) ? 32'h00 : 32'h71);
    end

    // Dropping blink_en while blank returns to lit next edge
    bus.blink_en = 1'b0;
    tick();
    check("unblink_seg", 32'(bus.SEG[6:0]), 32'h71);
    tick();
    check("unblink_hold", 32'(bus.SEG[6:0]), 32'h71);

    // Load in the toggle cycle wins and restarts the half-period
    bus.blink_en = 1'b1; bus.load = 1'b1; bus.value = 4'hF;
    tick();
    bus.load = 1'b0;
    tick(); tick(); tick();
    check("prio_pre", 32'(bus.SEG[6:0]), 32'h71);
    bus.load = 1'b1; bus.value = 4'hF;
    tick();
    bus.load = 1'b0;
    check("prio_seg", 32'(bus.SEG[6:0]), 32'h71);
    check("prio_ack", 32'(bus.ack),      32'h1);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("prio_blink", 32'(bus.SEG[6:0]), (k == 4) ? 32'h00 : 32'h71);
    end

    // Load 5 while blank: lit, never blinks
    bus.load = 1'b1; bus.value = 4'h5;
    tick();
    bus.load = 1'b0;
    check("blank_ld5_seg", 32'(bus.SEG[6:0]), 32'h6D);
    check("blank_ld5_ack", 32'(bus.ack),      32'h1);
    for (int k = 1; k <= 8; k++) begin
      tick();
      check("ld5_steady", 32'(bus.SEG[6:0]), 32'h6D);
    end

    // Blink on 0
    bus.load = 1'b1; bus.value = 4'h0;
    tick();
    bus.load = 1'b0;
    check("blink0_k0", 32'(bus.SEG[6:0]), 32'h3F);
    tick(); tick(); tick();
    check("blink0_k3", 32'(bus.SEG[6:0]), 32'h3F);
    tick();
    check("blink0_k4", 32'(bus.SEG[6:0]), 32'h00);

    // Reset mid-blink discards everything; IDLE does not blink
    reset_n = 1'b0;
    tick();
    check("midrst_seg",   32'(bus.SEG),   32'h00);
    check("midrst_shown", 32'(bus.shown), 32'h0);
    check("midrst_ack",   32'(bus.ack),   32'h0);
    reset_n = 1'b1;
    repeat (5) tick();
    check("idle_after_rst", 32'(bus.SEG), 32'h00);

`ifdef SEG_HEARTBEAT_EN
    // Heartbeat toggles every 8 cycles once out of IDLE
    bus.blink_en = 1'b0; bus.load = 1'b1; bus.value = 4'h3;
    tick();
    bus.load = 1'b0;
    check("hb_k0", 32'(bus.SEG[7]), 32'h0);
    for (int k = 1; k <= 20; k++) begin
      tick();
      check("hb_dp", 32'(bus.SEG[7]), 32'((k / 8) % 2));
    end
    reset_n = 1'b0;
    tick();
    check("hb_rst_seg", 32'(bus.SEG), 32'h00);
    reset_n = 1'b1;
    tick();
`else
    bus.blink_en = 1'b0; bus.load = 1'b1; bus.value = 4'h3;
    tick();
    bus.load = 1'b0;
    repeat (10) tick();
    check("dp_const_zero", 32'(bus.SEG), 32'h4F);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_seg_display
`default_nettype wire
